// File: rtl/pll_cfg_pkg.sv
// Shared types and divider-to-select encodings for the rPLL reconfiguration controller.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        LOCKED    = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int ODIV_IDX_MAX = 10;

    // ODSEL = 64 - ODIV/2 for ODIV {2,4,8,16,32,48,64,80,96,112,128}
    localparam logic [5:0] ODSEL_LUT [0:10] = '{
        6'd63, 6'd62, 6'd60, 6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8, 6'd0
    };

    function automatic logic [5:0] enc_idsel(input logic [5:0] idiv);
        return 6'd63 - idiv;
    endfunction

    function automatic logic [5:0] enc_fbdsel(input logic [5:0] fbdiv);
        return 6'd63 - fbdiv;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Divider request channel: valid/ready request with encoded-divider payload and reject pulse.
interface pll_reconfig_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idiv;
    logic [5:0] cfg_fbdiv;
    logic [3:0] cfg_odiv_idx;
    logic       cfg_err;

    modport master (output cfg_valid, cfg_idiv, cfg_fbdiv, cfg_odiv_idx,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_idiv, cfg_fbdiv, cfg_odiv_idx,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/pll_lock_sync.sv
// 2-FF synchroniser for raw PLL LOCK plus a consecutive-high filter counter.
// lock_s lags the pin by 2 edges; lock_q is high once the count reaches LOCK_FILTER_CYC.
module pll_lock_sync #(
    parameter int LOCK_FILTER_CYC = 64
) (
    input  logic clkin,
    input  logic rst,
    input  logic lock_raw,
    input  logic filt_clr,
    output logic lock_s,
    output logic lock_q
);
    localparam int FW = $clog2(LOCK_FILTER_CYC + 1);

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic [FW-1:0] filt_q, filt_d;

    always_comb begin
        meta_d = lock_raw;
        sync_d = meta_q;
        filt_d = filt_q;
        if (filt_clr || !sync_q) begin
            filt_d = '0;
        end else if (filt_q != FW'(LOCK_FILTER_CYC)) begin
            filt_d = filt_q + 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            filt_q <= filt_d;
        end
    end

    assign lock_s = sync_q;
    assign lock_q = (filt_q == FW'(LOCK_FILTER_CYC));
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL runtime reconfig: accepts divider requests, pulses PLL reset, qualifies LOCK with bounded retries.
// cfg_ready only in LOCKED/FAIL; PLL_AUTO_RELOCK_EN makes lock loss rerun the full reset sequence.
module pll_reconfig_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int RESET_HOLD_CYC   = 16,
    parameter int LOCK_TIMEOUT_CYC = 27000,
    parameter int LOCK_FILTER_CYC  = 64,
    parameter int MAX_RETRIES      = 3,
    parameter int DEF_IDIV         = 6,
    parameter int DEF_FBDIV        = 12,
    parameter int DEF_ODIV_IDX     = 3
) (
    input  logic                      clkin,
    input  logic                      rst,
    pll_reconfig_ctrl_if.slave        cfg,
    input  logic                      pll_lock_i,
    output logic                      pll_reset_o,
    output logic [5:0]                pll_idsel_o,
    output logic [5:0]                pll_fbdsel_o,
    output logic [5:0]                pll_odsel_o,
    output logic                      locked_o,
    output logic                      busy_o,
    output logic                      fail_o,
    output logic                      lock_lost_o,
    output logic [1:0]                retry_cnt_o
);
    localparam int CNT_MAX = (LOCK_TIMEOUT_CYC > RESET_HOLD_CYC) ? LOCK_TIMEOUT_CYC : RESET_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             lost_q, lost_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             pll_reset_q, pll_reset_d;
    logic             cfg_err_q, cfg_err_d;
    logic [5:0]       idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic             lock_s, lock_q;
    logic             idx_legal, accept;

    pll_lock_sync #(.LOCK_FILTER_CYC(LOCK_FILTER_CYC)) u_lock_sync (
        .clkin    (clkin),
        .rst      (rst),
        .lock_raw (pll_lock_i),
        .filt_clr (state_q != FILTER),
        .lock_s   (lock_s),
        .lock_q   (lock_q)
    );

    assign cfg.cfg_ready = ((state_q == LOCKED) || (state_q == FAIL)) && !rst;
    assign idx_legal     = (cfg.cfg_odiv_idx <= 4'(ODIV_IDX_MAX));
    assign accept        = cfg.cfg_valid && cfg.cfg_ready && idx_legal;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        lost_d   = lost_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;
        case (state_q)
            RST_HOLD: begin
                if (cnt_q == CNT_W'(RESET_HOLD_CYC - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK, FILTER: begin
                cnt_d = cnt_q + 1'b1;
                // A lock qualified on the last allowed cycle still counts as success
                if (state_q == FILTER && lock_s && lock_q) begin
                    state_d = LOCKED;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    cnt_d = '0;
                    if (retry_q < 2'(MAX_RETRIES)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = RST_HOLD;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (state_q == WAIT_LOCK && lock_s) begin
                    state_d = FILTER;
                end else if (state_q == FILTER && !lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    lost_d = 1'b1;
                    cnt_d  = '0;
`ifdef PLL_AUTO_RELOCK_EN
                    state_d = RST_HOLD;
                    retry_d = '0;
`else
                    state_d = WAIT_LOCK;
`endif
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RST_HOLD;
        endcase
        // A new request overrides any same-cycle lock-loss handling
        if (accept) begin
            state_d  = RST_HOLD;
            cnt_d    = '0;
            retry_d  = '0;
            lost_d   = 1'b0;
            idsel_d  = enc_idsel(cfg.cfg_idiv);
            fbdsel_d = enc_fbdsel(cfg.cfg_fbdiv);
            odsel_d  = ODSEL_LUT[cfg.cfg_odiv_idx];
        end
        cfg_err_d   = cfg.cfg_valid && cfg.cfg_ready && !idx_legal;
        locked_d    = (state_d == LOCKED);
        fail_d      = (state_d == FAIL);
        pll_reset_d = (state_d == RST_HOLD);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            pll_reset_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            idsel_q     <= enc_idsel(6'(DEF_IDIV));
            fbdsel_q    <= enc_fbdsel(6'(DEF_FBDIV));
            odsel_q     <= ODSEL_LUT[4'(DEF_ODIV_IDX)];
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            pll_reset_q <= pll_reset_d;
            cfg_err_q   <= cfg_err_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
        end
    end

    assign cfg.cfg_err  = cfg_err_q;
    assign pll_reset_o  = pll_reset_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_odsel_o  = odsel_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign lock_lost_o  = lost_q;
    assign retry_cnt_o  = retry_q;
    assign busy_o       = (state_q == RST_HOLD) || (state_q == WAIT_LOCK) || (state_q == FILTER);
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl; lock timeout shortened to 300 cycles to keep runs short.
module tb_pll_reconfig_ctrl;
    localparam int TMO = 300;

    logic       clkin = 1'b0;
    logic       rst   = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       pll_reset_o, locked_o, busy_o, fail_o, lock_lost_o;
    logic [5:0] pll_idsel_o, pll_fbdsel_o, pll_odsel_o;
    logic [1:0] retry_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    pll_reconfig_ctrl_if cfg_if ();

    pll_reconfig_ctrl #(
        .RESET_HOLD_CYC(16), .LOCK_TIMEOUT_CYC(TMO), .LOCK_FILTER_CYC(64), .MAX_RETRIES(3),
        .DEF_IDIV(6), .DEF_FBDIV(12), .DEF_ODIV_IDX(3)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .cfg          (cfg_if),
        .pll_lock_i   (pll_lock_i),
        .pll_reset_o  (pll_reset_o),
        .pll_idsel_o  (pll_idsel_o),
        .pll_fbdsel_o (pll_fbdsel_o),
        .pll_odsel_o  (pll_odsel_o),
        .locked_o     (locked_o),
        .busy_o       (busy_o),
        .fail_o       (fail_o),
        .lock_lost_o  (lock_lost_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the handshake completes on the following posedge.
    task automatic send(input logic [5:0] idiv, input logic [5:0] fbdiv, input logic [3:0] idx);
        cfg_if.cfg_idiv     = idiv;
        cfg_if.cfg_fbdiv    = fbdiv;
        cfg_if.cfg_odiv_idx = idx;
        cfg_if.cfg_valid    = 1'b1;
        @(negedge clkin);
        cfg_if.cfg_valid    = 1'b0;
    endtask

    task automatic pulse_width(output int w);
        w = 0;
        while (pll_reset_o && w < 100) begin
            w++;
            @(negedge clkin);
        end
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (!locked_o && n < 400) begin
            @(negedge clkin);
            n++;
        end
    endtask

    function automatic logic [17:0] sel3(input int a, input int b, input int c);
        return {6'(a), 6'(b), 6'(c)};
    endfunction

    initial begin
        int w, n, t, tf, rises;
        int rt [4];
        logic prev;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_idiv = '0;
        cfg_if.cfg_fbdiv = '0;
        cfg_if.cfg_odiv_idx = '0;
        repeat (3) @(negedge clkin);

        // reset state: {pll_reset,locked,fail,lost,ready,err,busy,retry}
        chk("rst_flags", {pll_reset_o, locked_o, fail_o, lock_lost_o, cfg_if.cfg_ready,
                          cfg_if.cfg_err, busy_o, retry_cnt_o}, 32'b1_0000_0100);
        chk("rst_sel", {pll_idsel_o, pll_fbdsel_o, pll_odsel_o}, sel3(57, 51, 56));

        // first lock: pin rises 100 cycles after reset release
        rst = 1'b0;
        pulse_width(w);
        chk("t1_reset_width", w, 16);
        repeat (100) @(negedge clkin);
        pll_lock_i = 1'b1;
        wait_locked(n);
        chk("t1_lock_latency", n, 68);
        chk("t1_ready_busy", {cfg_if.cfg_ready, busy_o}, 2'b10);

        // reconfigure idiv=2 fbdiv=24 idx=1
        send(6'd2, 6'd24, 4'd1);
        chk("t2_ready_drop", {cfg_if.cfg_ready, locked_o, pll_reset_o}, 3'b001);
        chk("t2_sel", {pll_idsel_o, pll_fbdsel_o, pll_odsel_o}, sel3(61, 39, 62));
        pll_lock_i = 1'b0;
        pulse_width(w);
        chk("t2_reset_width", w, 16);
        repeat (19) @(negedge clkin);
        pll_lock_i = 1'b1;
        wait_locked(n);
        chk("t2_relock_latency", n, 68);

        // illegal odiv index while locked
        send(6'd0, 6'd0, 4'd12);
        chk("t4_err_pulse", {cfg_if.cfg_err, locked_o, pll_reset_o}, 3'b110);
        chk("t4_sel_kept", {pll_idsel_o, pll_fbdsel_o, pll_odsel_o}, sel3(61, 39, 62));
        @(negedge clkin);
        chk("t4_err_clear", cfg_if.cfg_err, 0);

        // lock glitch at filter count 40 restarts the filter
        send(6'd6, 6'd12, 4'd3);
        pll_lock_i = 1'b0;
        pulse_width(w);
        repeat (10) @(negedge clkin);
        pll_lock_i = 1'b1;
        repeat (41) @(negedge clkin);
        pll_lock_i = 1'b0;
        @(negedge clkin);
        pll_lock_i = 1'b1;
        n = 42;
        while (!locked_o && n < 400) begin
            @(negedge clkin);
            n++;
        end
        chk("t3_glitch_latency", n, 110);

        // lock loss and request land on the same edge: request wins
        pll_lock_i = 1'b0;
        repeat (2) @(negedge clkin);
        chk("t7_ready_at_loss", cfg_if.cfg_ready, 1);
        send(6'd2, 6'd24, 4'd1);
        chk("t7_accept_wins", {lock_lost_o, pll_reset_o, locked_o}, 3'b010);
        pulse_width(w);
        pll_lock_i = 1'b1;
        wait_locked(n);
        chk("t7_relock", n, 68);

        // lock drop while locked
        pll_lock_i = 1'b0;
        repeat (3) @(negedge clkin);
        chk("t5_loss_flags", {locked_o, lock_lost_o}, 2'b01);
`ifdef PLL_AUTO_RELOCK_EN
        chk("t5_retry_zero", retry_cnt_o, 0);
        pulse_width(w);
        chk("t5_auto_pulse", w, 16);
`else
        w = 0;
        for (int i = 0; i < 20; i++) begin
            if (pll_reset_o) w++;
            @(negedge clkin);
        end
        chk("t5_no_pulse", w, 0);
        chk("t5_busy", busy_o, 1);
`endif
        pll_lock_i = 1'b1;
        wait_locked(n);
        chk("t5_relock", n, 68);
        chk("t5_lost_sticky", lock_lost_o, 1);
        send(6'd6, 6'd12, 4'd3);
        chk("t5_lost_cleared", lock_lost_o, 0);

        // lock never rises: 4 reset pulses then FAIL
        pll_lock_i = 1'b0;
        rises = 1;
        rt[0] = 0;
        t = 0;
        tf = -1;
        prev = pll_reset_o;
        while (t < 1500 && tf < 0) begin
            @(negedge clkin);
            t++;
            if (pll_reset_o && !prev) begin
                if (rises < 4) rt[rises] = t;
                chk("t6_retry_at_pulse", retry_cnt_o, 32'(rises));
                rises++;
            end
            if (fail_o) tf = t;
            prev = pll_reset_o;
        end
        chk("t6_pulse_count", rises, 4);
        chk("t6_pulse4_time", rt[3], 948);
        chk("t6_fail_time", tf, 1264);
        chk("t6_fail_flags", {retry_cnt_o, cfg_if.cfg_ready, busy_o, locked_o}, 5'b11100);
        send(6'd2, 6'd24, 4'd1);
        chk("t6_restart", {fail_o, pll_reset_o, retry_cnt_o}, 4'b0100);

        // reset mid-sequence with a pending request
        repeat (5) @(negedge clkin);
        rst = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_odiv_idx = 4'd1;
        repeat (2) @(negedge clkin);
        chk("t8_ready_in_rst", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        chk("t8_defaults", {pll_idsel_o, pll_fbdsel_o, pll_odsel_o}, sel3(57, 51, 56));
        chk("t8_flags", {pll_reset_o, retry_cnt_o, locked_o}, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end
endmodule
